cdb_arbiter: RTL and testbench
==============================

CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 2, meaning the number of entries in each per-source result queue (power of two, 2..8).
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port flush  input  1  misprediction flush; discards all queued and incoming results.
REQ-005 SHALL have ports alu_done/mul_done/div_done/load_done  input  1 each  result-valid strobe per source (src 0..3).
REQ-006 SHALL have ports alu_value/mul_value/div_value/load_value  input  32 each  result data.
REQ-007 SHALL have ports alu_PC/mul_PC/div_PC/load_PC  input  32 each  PC of the producing instruction.
REQ-008 SHALL have ports alu_phys/mul_phys/div_phys/load_phys  input  8 each  destination physical register.
REQ-009 SHALL have ports alu_ready/mul_ready/div_ready/load_ready  output  1 each  queue has a free slot (count < FIFO_DEPTH).
REQ-010 SHALL have ports cdb_valid  output  1, cdb_value  output  32, cdb_PC  output  32, cdb_phys  output  8, cdb_src  output  2: registered broadcast to ROB/RS.
REQ-011 SHALL have port overflow  output  1  sticky: a result was dropped on a full queue.

Function
REQ-012 SHALL hold one FIFO per source, each entry {value, PC, phys}; push on *_done at a rising edge when not flush.
REQ-013 SHALL select at most one non-empty FIFO head per cycle (grant) and pop it at the same edge it is registered onto the CDB.
REQ-014 SHALL drive cdb_valid=1 with the granted entry and cdb_src=source index in the cycle after the grant edge; otherwise cdb_valid=0 with data/PC/phys/src holding last values.
REQ-015 SHALL give latency: done sampled at edge k into an empty system -> cdb_valid high after edge k+1.
REQ-016 SHALL allow push and pop of the same FIFO at one edge; count unchanged, order preserved (FIFO order per source).
REQ-017 SHALL accept a push to a full FIFO only if that FIFO is popped at the same edge; otherwise drop the result and set overflow=1 until reset.
REQ-018 SHALL, on flush at an edge: empty all FIFOs, ignore *_done at that edge, force cdb_valid=0 after that edge, keep overflow and arbitration pointer unchanged.
REQ-019 SHALL wrap FIFO read/write pointers modulo FIFO_DEPTH; count width log2(FIFO_DEPTH)+1.
REQ-020 SHALL compute *_ready combinationally from count only (not from current-cycle pop).
REQ-021 SHALL produce no grant and cdb_valid=0 when all FIFOs are empty.

Reset
REQ-022 SHALL on reset clear all FIFO pointers/counts, cdb_valid=0, cdb_value=0, cdb_PC=0, cdb_phys=0, cdb_src=0, overflow=0, RR pointer=3; *_ready=1.
REQ-023 SHALL abandon any in-flight result on reset mid-operation; first grant after reset release follows REQ-015.

Configuration
REQ-024 SHALL, with CDB_RR_EN defined, use round-robin: search sources starting at (last_grant+1) mod 4, last_grant updated only on a grant.
REQ-025 SHALL, without CDB_RR_EN, use fixed priority ALU(0) > MUL(1) > DIV(2) > LOAD(3); RR pointer absent.

Verification
REQ-026 SHALL cover: alu_done=1, value=0x0000_00AA, PC=0x100, phys=0x05 at edge 1, idle after -> cdb_valid=1 after edge 2 with 0xAA/0x100/0x05/src=0, cdb_valid=0 after edge 3.
REQ-027 SHALL cover: all four done at one edge (values 1,2,3,4), CDB_RR_EN defined -> four consecutive cycles src 0,1,2,3 values 1,2,3,4; without macro same order, then alu pushes every cycle starve src 3.
REQ-028 SHALL cover: FIFO_DEPTH=2, mul_done three consecutive edges with values 7,8,9 while alu queue kept non-empty under fixed priority -> mul_ready=0 after second push, value 9 dropped, overflow=1.
REQ-029 SHALL cover: two div results queued, flush asserted at the edge a third div_done arrives -> cdb_valid=0 next cycle, no div result ever broadcast, div_ready=1.
REQ-030 SHALL cover: reset asserted asynchronously mid-cycle with 2 entries queued -> cdb_valid=0 and all *_ready=1 immediately, overflow=0.
REQ-031 SHALL cover: load FIFO full (2 entries), load_done at same edge load is granted -> entry accepted, overflow stays 0, three load values broadcast in order.

Source files
------------

// File: rtl/cdb_arbiter.sv
// ---------------------------------------------------------------------------
// cdb_arbiter
//
// Collects results from four execution units (ALU, MUL, DIV, LOAD), queues
// them in one small FIFO per source, and broadcasts at most one result per
// cycle on the common data bus (CDB) towards the ROB and reservation stations.
//
// Configuration macro:
//   CDB_RR_EN  defined   -> round-robin arbitration, search starts at
//                           (last_grant + 1) mod 4
//              undefined -> fixed priority ALU(0) > MUL(1) > DIV(2) > LOAD(3)
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   flush               misprediction flush: drops queued and incoming results
//   <src>_done          result-valid strobe (src = alu/mul/div/load, idx 0..3)
//   <src>_value/_PC     32-bit result data and producing-instruction PC
//   <src>_phys          8-bit destination physical register
//   <src>_ready         source queue has a free slot (count < FIFO_DEPTH)
//   cdb_valid/value/PC/phys/src   registered broadcast; data holds when idle
//   overflow            sticky: a result arrived at a full queue and was lost
//
// Handshake: a source may assert <src>_done in any cycle. The result is
// queued at the rising edge when the queue has room, or when the queue is
// full but its head is granted at that same edge. A result offered to a full,
// non-granted queue is dropped and raises overflow. <src>_ready is only a
// hint derived from the queue count; it does not account for a same-cycle pop.
// ---------------------------------------------------------------------------
module cdb_arbiter #(
    parameter int FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        alu_done,
    input  logic        mul_done,
    input  logic        div_done,
    input  logic        load_done,
    input  logic [31:0] alu_value,
    input  logic [31:0] mul_value,
    input  logic [31:0] div_value,
    input  logic [31:0] load_value,
    input  logic [31:0] alu_PC,
    input  logic [31:0] mul_PC,
    input  logic [31:0] div_PC,
    input  logic [31:0] load_PC,
    input  logic [7:0]  alu_phys,
    input  logic [7:0]  mul_phys,
    input  logic [7:0]  div_phys,
    input  logic [7:0]  load_phys,
    output logic        alu_ready,
    output logic        mul_ready,
    output logic        div_ready,
    output logic        load_ready,
    output logic        cdb_valid,
    output logic [31:0] cdb_value,
    output logic [31:0] cdb_PC,
    output logic [7:0]  cdb_phys,
    output logic [1:0]  cdb_src,
    output logic        overflow
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int EW = 72;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    // Entry layout: {value[71:40], PC[39:8], phys[7:0]}
    logic [3:0]    w_done;
    logic [EW-1:0] w_in [4];
    logic [EW-1:0] r_mem [4][FIFO_DEPTH];
    logic [PW-1:0] r_wr_ptr [4];
    logic [PW-1:0] r_rd_ptr [4];
    logic [CW-1:0] r_count [4];

    logic [3:0]    w_nonempty;
    logic [3:0]    w_full;
    logic [3:0]    w_push;
    logic [3:0]    w_pop;
    logic [3:0]    w_drop;
    logic          w_gnt_valid;
    logic [1:0]    w_gnt_src;
    logic [EW-1:0] w_head;

    logic          r_cdb_valid;
    logic [31:0]   r_cdb_value;
    logic [31:0]   r_cdb_PC;
    logic [7:0]    r_cdb_phys;
    logic [1:0]    r_cdb_src;
    logic          r_overflow;

    assign w_done = {load_done, div_done, mul_done, alu_done};
    assign w_in[0] = {alu_value,  alu_PC,  alu_phys};
    assign w_in[1] = {mul_value,  mul_PC,  mul_phys};
    assign w_in[2] = {div_value,  div_PC,  div_phys};
    assign w_in[3] = {load_value, load_PC, load_phys};

    always_comb begin
        w_nonempty = '0;
        w_full     = '0;
        for (int s = 0; s < 4; s++) begin
            w_nonempty[s] = (r_count[s] != '0);
            w_full[s]     = (r_count[s] == FULL_CNT);
        end
    end

`ifdef CDB_RR_EN
    logic [1:0] r_rr_ptr;
    logic [1:0] w_rr_cand;

    // First non-empty queue found walking upward from the one after the
    // last grant.
    always_comb begin
        w_gnt_valid = 1'b0;
        w_gnt_src   = 2'd0;
        w_rr_cand   = r_rr_ptr;
        for (int k = 0; k < 4; k++) begin
            w_rr_cand = r_rr_ptr + 2'(k + 1);
            if (!w_gnt_valid && w_nonempty[w_rr_cand]) begin
                w_gnt_valid = 1'b1;
                w_gnt_src   = w_rr_cand;
            end
        end
    end

    // The pointer only moves on a real broadcast, so a flush leaves it alone.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rr_ptr <= 2'd3;
        end else if (!flush && w_gnt_valid) begin
            r_rr_ptr <= w_gnt_src;
        end
    end
`else
    // Descending scan so the lowest index wins.
    always_comb begin
        w_gnt_valid = 1'b0;
        w_gnt_src   = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (w_nonempty[k]) begin
                w_gnt_valid = 1'b1;
                w_gnt_src   = 2'(k);
            end
        end
    end
`endif

    // A push into a full queue is legal when the head leaves at the same edge.
    always_comb begin
        w_pop  = '0;
        w_push = '0;
        w_drop = '0;
        for (int s = 0; s < 4; s++) begin
            w_pop[s]  = w_gnt_valid && (w_gnt_src == 2'(s)) && !flush;
            w_push[s] = w_done[s] && !flush && (!w_full[s] || w_pop[s]);
            w_drop[s] = w_done[s] && !flush && w_full[s] && !w_pop[s];
        end
    end

    assign w_head = r_mem[w_gnt_src][r_rd_ptr[w_gnt_src]];

    always_ff @(posedge clk) begin
        for (int s = 0; s < 4; s++) begin
            if (w_push[s]) begin
                r_mem[s][r_wr_ptr[s]] <= w_in[s];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < 4; s++) begin
                r_wr_ptr[s] <= '0;
                r_rd_ptr[s] <= '0;
                r_count[s]  <= '0;
            end
            r_overflow <= 1'b0;
        end else if (flush) begin
            for (int s = 0; s < 4; s++) begin
                r_wr_ptr[s] <= '0;
                r_rd_ptr[s] <= '0;
                r_count[s]  <= '0;
            end
        end else begin
            for (int s = 0; s < 4; s++) begin
                if (w_push[s]) begin
                    r_wr_ptr[s] <= r_wr_ptr[s] + PW'(1);
                end
                if (w_pop[s]) begin
                    r_rd_ptr[s] <= r_rd_ptr[s] + PW'(1);
                end
                r_count[s] <= r_count[s] + CW'(w_push[s]) - CW'(w_pop[s]);
            end
            if (|w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // CDB payload holds its last value while idle; only valid is cleared.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cdb_valid <= 1'b0;
            r_cdb_value <= '0;
            r_cdb_PC    <= '0;
            r_cdb_phys  <= '0;
            r_cdb_src   <= '0;
        end else if (flush) begin
            r_cdb_valid <= 1'b0;
        end else begin
            r_cdb_valid <= w_gnt_valid;
            if (w_gnt_valid) begin
                r_cdb_value <= w_head[71:40];
                r_cdb_PC    <= w_head[39:8];
                r_cdb_phys  <= w_head[7:0];
                r_cdb_src   <= w_gnt_src;
            end
        end
    end

    assign alu_ready  = !w_full[0];
    assign mul_ready  = !w_full[1];
    assign div_ready  = !w_full[2];
    assign load_ready = !w_full[3];

    assign cdb_valid = r_cdb_valid;
    assign cdb_value = r_cdb_value;
    assign cdb_PC    = r_cdb_PC;
    assign cdb_phys  = r_cdb_phys;
    assign cdb_src   = r_cdb_src;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_cdb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cdb_arbiter
//
// Bench for cdb_arbiter with FIFO_DEPTH = 2. Expected broadcasts
// {src, value, PC, phys} are queued in exp_q as stimulus is driven; a
// negedge monitor pops and compares every cdb_valid cycle. Scenario tasks
// check timing, ready, overflow and reset behaviour inline.
// Scenarios that rely on fixed priority are built only without CDB_RR_EN.
// ---------------------------------------------------------------------------
module tb_cdb_arbiter;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        tb_done [4];
    logic [31:0] tb_value [4];
    logic [31:0] tb_pc [4];
    logic [7:0]  tb_phys [4];

    logic        alu_ready, mul_ready, div_ready, load_ready;
    logic        cdb_valid;
    logic [31:0] cdb_value;
    logic [31:0] cdb_PC;
    logic [7:0]  cdb_phys;
    logic [1:0]  cdb_src;
    logic        overflow;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [73:0] exp_q[$];
    logic [73:0] mon_exp;

    cdb_arbiter #(.FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .alu_done   (tb_done[0]),
        .mul_done   (tb_done[1]),
        .div_done   (tb_done[2]),
        .load_done  (tb_done[3]),
        .alu_value  (tb_value[0]),
        .mul_value  (tb_value[1]),
        .div_value  (tb_value[2]),
        .load_value (tb_value[3]),
        .alu_PC     (tb_pc[0]),
        .mul_PC     (tb_pc[1]),
        .div_PC     (tb_pc[2]),
        .load_PC    (tb_pc[3]),
        .alu_phys   (tb_phys[0]),
        .mul_phys   (tb_phys[1]),
        .div_phys   (tb_phys[2]),
        .load_phys  (tb_phys[3]),
        .alu_ready  (alu_ready),
        .mul_ready  (mul_ready),
        .div_ready  (div_ready),
        .load_ready (load_ready),
        .cdb_valid  (cdb_valid),
        .cdb_value  (cdb_value),
        .cdb_PC     (cdb_PC),
        .cdb_phys   (cdb_phys),
        .cdb_src    (cdb_src),
        .overflow   (overflow)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (reset === 1'b0 && cdb_valid === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL cdb_unexpected: got src=%0d value=%h pc=%h phys=%h, required no broadcast",
                         cdb_src, cdb_value, cdb_PC, cdb_phys);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({cdb_src, cdb_value, cdb_PC, cdb_phys} !== mon_exp) begin
                    n_fail++;
                    $display("FAIL cdb_data: got src=%0d value=%h pc=%h phys=%h, required src=%0d value=%h pc=%h phys=%h",
                             cdb_src, cdb_value, cdb_PC, cdb_phys,
                             mon_exp[73:72], mon_exp[71:40], mon_exp[39:8], mon_exp[7:0]);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        flush = 1'b0;
        for (int s = 0; s < 4; s++) tb_done[s] = 1'b0;
    endtask

    task automatic drive(input int s, input logic [31:0] v, input logic [31:0] pc, input logic [7:0] ph);
        tb_done[s]  = 1'b1;
        tb_value[s] = v;
        tb_pc[s]    = pc;
        tb_phys[s]  = ph;
    endtask

    task automatic expect_out(input logic [1:0] s, input logic [31:0] v, input logic [31:0] pc, input logic [7:0] ph);
        exp_q.push_back({s, v, pc, ph});
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_in();
        tick();
        tick();
        exp_q.delete();
        reset = 1'b0;
    endtask

    // Bounded wait for the scoreboard to consume everything expected.
    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        tick();
        tick();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        #12;
        n_checks++;
        if (cdb_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b, required 0", cdb_valid); end
        n_checks++;
        if ({cdb_value, cdb_PC, cdb_phys, cdb_src} !== 74'd0) begin
            n_fail++; $display("FAIL reset_payload: got value=%h pc=%h phys=%h src=%0d, required all zero", cdb_value, cdb_PC, cdb_phys, cdb_src);
        end
        n_checks++;
        if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b, required 0", overflow); end
        n_checks++;
        if ({load_ready, div_ready, mul_ready, alu_ready} !== 4'hF) begin
            n_fail++; $display("FAIL reset_ready: got %b, required 1111", {load_ready, div_ready, mul_ready, alu_ready});
        end
        tick();
        reset = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        drive(0, 32'h0000_00AA, 32'h100, 8'h05);
        expect_out(2'd0, 32'h0000_00AA, 32'h100, 8'h05);
        tick();
        clear_in();
        n_checks++;
        if (cdb_valid !== 1'b0) begin n_fail++; $display("FAIL single_edge1_valid: got %b, required 0", cdb_valid); end
        tick();
        n_checks++;
        if (cdb_valid !== 1'b1) begin n_fail++; $display("FAIL single_edge2_valid: got %b, required 1", cdb_valid); end
        tick();
        n_checks++;
        if (cdb_valid !== 1'b0) begin n_fail++; $display("FAIL single_edge3_valid: got %b, required 0", cdb_valid); end
        n_checks++;
        if (cdb_value !== 32'h0000_00AA || cdb_src !== 2'd0) begin
            n_fail++; $display("FAIL single_hold: got value=%h src=%0d, required value=000000aa src=0", cdb_value, cdb_src);
        end
        drain();
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL single_drain: got %0d pending, required 0", exp_q.size()); end
    endtask

    task automatic test_all_four();
        logic [31:0] av [6];
        logic [31:0] lv;
        do_reset();
        for (int s = 0; s < 4; s++) begin
            drive(s, 32'(s + 1), 32'h200 + 32'(4 * s), 8'h10 + 8'(s));
            expect_out(2'(s), 32'(s + 1), 32'h200 + 32'(4 * s), 8'h10 + 8'(s));
        end
        tick();
        clear_in();
        n_checks++;
        if (cdb_valid !== 1'b0) begin n_fail++; $display("FAIL all4_latency: got %b, required 0", cdb_valid); end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if (cdb_valid !== 1'b1 || cdb_src !== 2'(i)) begin
                n_fail++; $display("FAIL all4_order: got valid=%b src=%0d, required valid=1 src=%0d", cdb_valid, cdb_src, i);
            end
        end
        tick();
        n_checks++;
        if (cdb_valid !== 1'b0) begin n_fail++; $display("FAIL all4_idle: got %b, required 0", cdb_valid); end

        // ALU pushes every cycle while one LOAD result waits.
        lv = $urandom;
        for (int i = 0; i < 6; i++) av[i] = $urandom;
`ifdef CDB_RR_EN
        expect_out(2'd0, av[0], 32'h300, 8'h20);
        expect_out(2'd3, lv, 32'h400, 8'h30);
        for (int i = 1; i < 6; i++) expect_out(2'd0, av[i], 32'h300 + 32'(i), 8'h20);
`else
        for (int i = 0; i < 6; i++) expect_out(2'd0, av[i], 32'h300 + 32'(i), 8'h20);
        expect_out(2'd3, lv, 32'h400, 8'h30);
`endif
        for (int i = 0; i < 6; i++) begin
            drive(0, av[i], 32'h300 + 32'(i), 8'h20);
            if (i == 0) drive(3, lv, 32'h400, 8'h30);
            tick();
            clear_in();
        end
`ifndef CDB_RR_EN
        n_checks++;
        if (load_ready !== 1'b1 || cdb_src !== 2'd0) begin
            n_fail++; $display("FAIL starve_state: got load_ready=%b src=%0d, required load_ready=1 src=0", load_ready, cdb_src);
        end
`endif
        drain();
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL all4_drain: got %0d pending, required 0", exp_q.size()); end
    endtask

`ifndef CDB_RR_EN
    task automatic test_overflow();
        do_reset();
        drive(0, 32'hA1, 32'h500, 8'h01);
        drive(1, 32'd7, 32'h600, 8'h41);
        expect_out(2'd0, 32'hA1, 32'h500, 8'h01);
        tick();
        n_checks++;
        if (mul_ready !== 1'b1 || overflow !== 1'b0) begin
            n_fail++; $display("FAIL ovf_push1: got mul_ready=%b overflow=%b, required 1 0", mul_ready, overflow);
        end
        drive(0, 32'hA2, 32'h504, 8'h02);
        drive(1, 32'd8, 32'h604, 8'h42);
        expect_out(2'd0, 32'hA2, 32'h504, 8'h02);
        tick();
        n_checks++;
        if (mul_ready !== 1'b0 || overflow !== 1'b0) begin
            n_fail++; $display("FAIL ovf_push2: got mul_ready=%b overflow=%b, required 0 0", mul_ready, overflow);
        end
        drive(0, 32'hA3, 32'h508, 8'h03);
        drive(1, 32'd9, 32'h608, 8'h43);
        expect_out(2'd0, 32'hA3, 32'h508, 8'h03);
        tick();
        clear_in();
        n_checks++;
        if (mul_ready !== 1'b0 || overflow !== 1'b1) begin
            n_fail++; $display("FAIL ovf_push3: got mul_ready=%b overflow=%b, required 0 1", mul_ready, overflow);
        end
        expect_out(2'd1, 32'd7, 32'h600, 8'h41);
        expect_out(2'd1, 32'd8, 32'h604, 8'h42);
        drain();
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL ovf_drain: got %0d pending, required 0", exp_q.size()); end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_checks++;
        if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b, required 1", overflow); end
    endtask

    task automatic test_full_pushpop();
        do_reset();
        expect_out(2'd0, 32'hB1, 32'h700, 8'h11);
        expect_out(2'd0, 32'hB2, 32'h704, 8'h12);
        expect_out(2'd3, 32'hC1, 32'h800, 8'h61);
        expect_out(2'd3, 32'hC2, 32'h804, 8'h62);
        expect_out(2'd3, 32'hC3, 32'h808, 8'h63);
        drive(0, 32'hB1, 32'h700, 8'h11);
        drive(3, 32'hC1, 32'h800, 8'h61);
        tick();
        drive(0, 32'hB2, 32'h704, 8'h12);
        drive(3, 32'hC2, 32'h804, 8'h62);
        tick();
        clear_in();
        n_checks++;
        if (load_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %b, required 0", load_ready); end
        tick();
        drive(3, 32'hC3, 32'h808, 8'h63);
        tick();
        clear_in();
        n_checks++;
        if (overflow !== 1'b0 || load_ready !== 1'b0) begin
            n_fail++; $display("FAIL full_pushpop: got overflow=%b load_ready=%b, required 0 0", overflow, load_ready);
        end
        drain();
        n_checks++;
        if (exp_q.size() != 0 || overflow !== 1'b0) begin
            n_fail++; $display("FAIL full_drain: got pending=%0d overflow=%b, required 0 0", exp_q.size(), overflow);
        end
    endtask
`endif

    task automatic test_flush();
        do_reset();
        drive(0, 32'hD1, 32'h900, 8'h21);
        drive(2, 32'hE1, 32'hA00, 8'h51);
        expect_out(2'd0, 32'hD1, 32'h900, 8'h21);
        tick();
        drive(0, 32'hD2, 32'h904, 8'h22);
        drive(2, 32'hE2, 32'hA04, 8'h52);
        tick();
        n_checks++;
        if (div_ready !== 1'b0) begin n_fail++; $display("FAIL flush_div_full: got %b, required 0", div_ready); end
        flush = 1'b1;
        drive(0, 32'hD3, 32'h908, 8'h23);
        drive(2, 32'hE3, 32'hA08, 8'h53);
        tick();
        clear_in();
        n_checks++;
        if (cdb_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b, required 0", cdb_valid); end
        n_checks++;
        if (div_ready !== 1'b1 || alu_ready !== 1'b1) begin
            n_fail++; $display("FAIL flush_ready: got div_ready=%b alu_ready=%b, required 1 1", div_ready, alu_ready);
        end
        for (int i = 0; i < 6; i++) tick();
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL flush_drain: got %0d pending, required 0", exp_q.size()); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive(0, 32'hF1, 32'hB00, 8'h31);
        drive(1, 32'hF2, 32'hB04, 8'h32);
        drive(2, 32'hF3, 32'hB08, 8'h33);
        expect_out(2'd0, 32'hF1, 32'hB00, 8'h31);
        tick();
        clear_in();
        tick();
        #6;
        reset = 1'b1;
        #1;
        n_checks++;
        if (cdb_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %b, required 0", cdb_valid); end
        n_checks++;
        if ({load_ready, div_ready, mul_ready, alu_ready} !== 4'hF || overflow !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_state: got ready=%b overflow=%b, required 1111 0",
                               {load_ready, div_ready, mul_ready, alu_ready}, overflow);
        end
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL rstmid_pending: got %0d pending, required 0", exp_q.size()); end
        exp_q.delete();
        tick();
        reset = 1'b0;
        drive(3, 32'h1234_5678, 32'hC00, 8'h77);
        expect_out(2'd3, 32'h1234_5678, 32'hC00, 8'h77);
        tick();
        clear_in();
        n_checks++;
        if (cdb_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_lat1: got %b, required 0", cdb_valid); end
        tick();
        n_checks++;
        if (cdb_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_lat2: got %b, required 1", cdb_valid); end
        drain();
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL rstmid_drain: got %0d pending, required 0", exp_q.size()); end
    endtask

    // ---------------- main sequence and report ----------------
    initial begin
        reset = 1'b1;
        flush = 1'b0;
        for (int s = 0; s < 4; s++) begin
            tb_done[s]  = 1'b0;
            tb_value[s] = '0;
            tb_pc[s]    = '0;
            tb_phys[s]  = '0;
        end
        test_reset();
        test_single();
        test_all_four();
`ifndef CDB_RR_EN
        test_overflow();
        test_full_pushpop();
`endif
        test_flush();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
